// File: rtl/ray_sequencer.sv
// Frame controller: walks ray_col over NUM_RAYS columns, hands each to the feeder (valid/ready), waits on proc_done or watchdog.
// Start-to-FEED latency 1 cycle; FEED holds indefinitely while feed_ready is low; one-cycle DONE per frame.
module ray_sequencer #(
  parameter int NUM_RAYS   = 320,
  parameter int COL_W      = 9,
  parameter int TIMEOUT    = 256,
  parameter int TMO_W      = 9,
  parameter int CONTINUOUS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             feed_valid,
  input  logic             feed_ready,
  output logic [COL_W-1:0] ray_col,
  input  logic             proc_done,
  output logic             ray_timeout,
  output logic             frame_done,
  output logic             busy,
  output logic [1:0]       state,
  output logic [15:0]      frame_cnt
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] FEED    = 2'b01;
  localparam logic [1:0] PROCESS = 2'b10;
  localparam logic [1:0] DONE    = 2'b11;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_RAYS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic             start_d;
  logic             start_pulse;
  logic [TMO_W-1:0] watchdog;
  logic             expired;

  assign start_pulse = start & ~start_d;
  assign expired     = (watchdog == TMO_LAST);

  assign feed_valid = (state == FEED);
  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ray_col     <= '0;
      watchdog    <= '0;
      frame_cnt   <= '0;
      ray_timeout <= 1'b0;
      // Track start through reset so a level held across reset is not seen as a new edge.
      start_d     <= start;
    end else begin
      start_d     <= start;
      ray_timeout <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        ray_col <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_pulse) begin
              state   <= FEED;
              ray_col <= '0;
            end
          end
          FEED: begin
            if (feed_ready) begin
              state    <= PROCESS;
              watchdog <= '0;
            end
          end
          PROCESS: begin
            watchdog <= watchdog + TMO_W'(1);
            // proc_done takes precedence over a coincident watchdog expiry.
            if (proc_done || expired) begin
              ray_timeout <= ~proc_done;
              if (ray_col == LAST_COL) begin
                state     <= DONE;
                frame_cnt <= frame_cnt + 16'd1;
              end else begin
                state   <= FEED;
                ray_col <= ray_col + COL_W'(1);
              end
            end
          end
          DONE: begin
            if (CONTINUOUS != 0) begin
              state   <= FEED;
              ray_col <= '0;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ray_sequencer.sv
// Bench for ray_sequencer: directed frame scenarios plus random stimulus, every cycle checked against a frame-level model.
module tb_ray_sequencer;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort, feed_ready, proc_done;

  logic       a_fv, a_tmo, a_fd, a_busy;
  logic [8:0] a_col;
  logic [1:0] a_state;
  logic [15:0] a_fcnt;
  logic       c_fv, c_tmo, c_fd, c_busy;
  logic [8:0] c_col;
  logic [1:0] c_state;
  logic [15:0] c_fcnt;

  ray_sequencer #(.NUM_RAYS(4), .COL_W(9), .TIMEOUT(TMO), .TMO_W(4), .CONTINUOUS(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .feed_valid(a_fv), .feed_ready(feed_ready), .ray_col(a_col), .proc_done(proc_done),
    .ray_timeout(a_tmo), .frame_done(a_fd), .busy(a_busy), .state(a_state), .frame_cnt(a_fcnt)
  );

  ray_sequencer #(.NUM_RAYS(2), .COL_W(9), .TIMEOUT(TMO), .TMO_W(4), .CONTINUOUS(1)) dut_c (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .feed_valid(c_fv), .feed_ready(feed_ready), .ray_col(c_col), .proc_done(proc_done),
    .ray_timeout(c_tmo), .frame_done(c_fd), .busy(c_busy), .state(c_state), .frame_cnt(c_fcnt)
  );

  // phase: 0 waiting, 1 offering a column, 2 ray in flight, 3 frame wrap-up
  typedef struct packed {
    int phase;
    int col;
    int dwell;
    int frames;
    bit prev_start;
    bit tmo;
  } mdl_t;

  mdl_t ma, mc;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fd, pc, tcnt, idle;
  int   cols[$];
  bit   st_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic mdl_t mstep(mdl_t m, int nr, bit cont, bit rst, bit st, bit ab, bit fr, bit pd);
    mdl_t n;
    bit   rise;
    n = m;
    rise = st && !m.prev_start;
    n.prev_start = st;
    n.tmo = 1'b0;
    if (rst) begin
      n.phase = 0; n.col = 0; n.dwell = 0; n.frames = 0;
    end else if (ab) begin
      n.phase = 0; n.col = 0;
    end else begin
      case (m.phase)
        0: if (rise) begin n.phase = 1; n.col = 0; end
        1: if (fr) begin n.phase = 2; n.dwell = 0; end
        2: begin
          n.dwell = m.dwell + 1;
          if (pd || n.dwell == TMO) begin
            n.tmo = !pd;
            if (m.col == nr - 1) begin
              n.phase = 3;
              n.frames = (m.frames + 1) % 65536;
            end else begin
              n.phase = 1;
              n.col = m.col + 1;
            end
          end
        end
        default: begin
          n.phase = cont ? 1 : 0;
          if (cont) n.col = 0;
        end
      endcase
    end
    return n;
  endfunction

  task automatic cmp_dut(input string p, input mdl_t m, input logic [1:0] s, input logic [8:0] c,
                         input logic fv, input logic fdn, input logic bz, input logic tm, input logic [15:0] fc);
    chk({p, "_state"}, s, m.phase);
    chk({p, "_col"}, c, m.col);
    chk({p, "_feed_valid"}, fv, m.phase == 1);
    chk({p, "_frame_done"}, fdn, m.phase == 3);
    chk({p, "_busy"}, bz, m.phase != 0);
    chk({p, "_timeout"}, tm, m.tmo);
    chk({p, "_frame_cnt"}, fc, m.frames);
  endtask

  task automatic cycle(input bit rst, input bit st, input bit ab, input bit fr, input bit pd);
    reset = rst; start = st; abort = ab; feed_ready = fr; proc_done = pd;
    ma = mstep(ma, 4, 1'b0, rst, st, ab, fr, pd);
    mc = mstep(mc, 2, 1'b1, rst, st, ab, fr, pd);
    @(negedge clk);
    cmp_dut("a", ma, a_state, a_col, a_fv, a_fd, a_busy, a_tmo, a_fcnt);
    cmp_dut("c", mc, c_state, c_col, c_fv, c_fd, c_busy, c_tmo, c_fcnt);
  endtask

  task automatic go(input bit st, input bit ab, input bit fr, input bit pd);
    cycle(1'b0, st, ab, fr, pd);
  endtask

  initial begin
    ma = '0;
    mc = '0;
    st_r = 1'b0;
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_state", a_state, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_col", a_col, 0);
    chk("rst_fcnt", a_fcnt, 0);

    // Basic 4-column frame, proc_done in the second PROCESS cycle of each ray
    go(0, 0, 1, 0);
    go(1, 0, 1, 0);
    chk("start_latency", a_state, 1);
    fd = 0;
    cols.delete();
    for (int i = 0; i < 100 && ma.phase != 0; i++) begin
      if (a_state == 2'b01) cols.push_back(int'(a_col));
      go(1, 0, 1, ma.phase == 2 && ma.dwell == 1);
      if (a_fd) fd++;
    end
    chk("f1_ncols", cols.size(), 4);
    foreach (cols[k]) chk($sformatf("f1_col%0d", k), cols[k], k);
    chk("f1_frame_done", fd, 1);
    chk("f1_fcnt", a_fcnt, 1);
    chk("f1_state", a_state, 0);
    chk("f1_busy", a_busy, 0);

    // Feeder stall, then a watchdog-retired ray on column 2
    go(0, 0, 0, 0);
    go(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_state", a_state, 1);
      chk("hold_valid", a_fv, 1);
      chk("hold_col", a_col, 0);
      go(1, 0, 0, 0);
    end
    go(1, 0, 1, 0);
    chk("hold_advance", a_state, 2);
    fd = 0; pc = 0; tcnt = 0;
    for (int i = 0; i < 200 && ma.phase != 0; i++) begin
      go(1, 0, 1, ma.phase == 2 && ma.col != 2 && ma.dwell == 0);
      if (a_state == 2'b10 && a_col == 9'd2) pc++;
      if (a_tmo) begin
        tcnt++;
        chk("tmo_after_cycles", pc, TMO);
        chk("tmo_next_col", a_col, 3);
      end
      if (a_fd) fd++;
    end
    chk("tmo_pulses", tcnt, 1);
    chk("tmo_frame_done", fd, 1);
    chk("tmo_fcnt", a_fcnt, 2);

    // proc_done coincident with watchdog expiry on column 1
    go(0, 0, 1, 0);
    go(1, 0, 1, 0);
    fd = 0; pc = 0; tcnt = 0;
    for (int i = 0; i < 200 && ma.phase != 0; i++) begin
      go(1, 0, 1, ma.phase == 2 && (ma.col == 1 ? ma.dwell == TMO - 1 : ma.dwell == 0));
      if (a_state == 2'b10 && a_col == 9'd1) pc++;
      if (a_tmo) tcnt++;
      if (a_fd) fd++;
    end
    chk("coin_proc_cycles", pc, TMO);
    chk("coin_no_timeout", tcnt, 0);
    chk("coin_frame_done", fd, 1);
    chk("coin_fcnt", a_fcnt, 3);

    // Abort while processing column 2
    go(0, 0, 1, 0);
    go(1, 0, 1, 0);
    for (int i = 0; i < 100 && !(ma.phase == 2 && ma.col == 2); i++)
      go(1, 0, 1, ma.phase == 2 && ma.dwell == 0);
    go(1, 1, 1, 0);
    chk("abort_state", a_state, 0);
    chk("abort_col", a_col, 0);
    chk("abort_fcnt", a_fcnt, 3);
    chk("abort_no_done", a_fd, 0);
    go(1, 0, 1, 0);
    chk("abort_level_ignored", a_state, 0);
    go(0, 0, 1, 0);
    go(1, 0, 1, 0);
    chk("restart_state", a_state, 1);
    chk("restart_col", a_col, 0);
    for (int i = 0; i < 100 && ma.phase != 0; i++)
      go(1, 0, 1, ma.phase == 2 && ma.dwell == 0);
    chk("restart_fcnt", a_fcnt, 4);

    // Start held through reset, then continuous mode on the 2-ray instance
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      go(1, 0, 1, 0);
      chk("held_a_idle", a_state, 0);
      chk("held_c_idle", c_state, 0);
    end
    go(0, 0, 1, 0);
    go(1, 0, 1, 0);
    chk("cont_start", c_state, 1);
    fd = 0; idle = 0;
    for (int i = 0; i < 200 && mc.frames < 3; i++) begin
      go(i != 5, 0, 1, mc.phase == 2 && mc.dwell == 0);
      if (c_state == 2'b00) idle++;
      if (c_fd) fd++;
    end
    chk("cont_fcnt", c_fcnt, 3);
    chk("cont_frame_done", fd, 3);
    chk("cont_no_idle", idle, 0);

    // Random traffic, occasional abort and reset
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(9) == 0) st_r = !st_r;
      cycle($urandom_range(199) == 0, st_r, $urandom_range(49) == 0,
            $urandom_range(9) < 7, $urandom_range(9) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
